// File: rtl/sram_mem_port.sv
// sram_mem_port: bridges the CPU's tagged memory port to the board's asynchronous
// 32-bit SRAM (two 16-bit chips) on the shared Flash-SRAM-Ethernet bus.
// Every output is registered. The data bus is driven only from registered
// enable/data, so read strobes and bus drive never overlap.
module sram_mem_port #(
   parameter int READ_WAIT  = 1,
   parameter int WRITE_WAIT = 1,
   parameter int ADDR_BITS  = 18
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        mem_waitrequest,
   input  logic [1:0]  mem_id,
   input  logic [29:0] mem_address,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_writedata,
   input  logic [3:0]  mem_writedatamask,
   output logic [31:0] mem_readdata,
   output logic [1:0]  mem_readdataid,
   output logic [22:0] sram_a,
   inout  wire  [31:0] sram_d,
   output logic        sram_cs_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic [3:0]  sram_be_n
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_t;

   state_t      state, state_nxt;
   logic [2:0]  wait_cnt, wait_cnt_nxt;
   logic        accept;
   logic        is_write;
   logic [22:0] word_addr;
   logic        unused_addr_bits;

   // Request-side latches (data path, no reset needed)
   logic [1:0]  id_q;
   logic [31:0] wdata_q;

   // Next values of the registered outputs
   logic        drive_q, drive_nxt;
   logic        waitrequest_nxt;
   logic [31:0] readdata_nxt;
   logic [1:0]  readdataid_nxt;
   logic [22:0] sram_a_nxt;
   logic        cs_n_nxt, oe_n_nxt, we_n_nxt;
   logic [3:0]  be_n_nxt;

   // Upper address bits alias onto the SRAM; they are intentionally dropped.
   assign unused_addr_bits = ^mem_address;

   // A write wins over a simultaneous read; the read is simply dropped.
   assign accept   = (state == S_IDLE) && !mem_waitrequest && (mem_read || mem_write);
   assign is_write = mem_write;

   // The data bus is driven straight from registers.
   assign sram_d = drive_q ? wdata_q : 'z;

   // Word address placed on the byte address lines, upper lines held at zero
   always_comb begin
      word_addr = '0;
      word_addr[ADDR_BITS+1:2] = mem_address[ADDR_BITS-1:0];
   end

   // State register and wait counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Next-state logic: strobe length set by the counter loaded on accept
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_write) begin
                  state_nxt    = S_WRITE;
                  wait_cnt_nxt = 3'(WRITE_WAIT);
               end else begin
                  state_nxt    = S_READ;
                  wait_cnt_nxt = 3'(READ_WAIT);
               end
            end
         end
         S_READ, S_WRITE: begin
            wait_cnt_nxt = wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) begin
               state_nxt = (state == S_READ) ? S_IDLE : S_TURN;
            end
         end
         S_TURN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output logic: next values of every registered output and the bus enable
   always_comb begin
      waitrequest_nxt = mem_waitrequest;
      readdata_nxt    = mem_readdata;
      readdataid_nxt  = 2'd0;
      sram_a_nxt      = sram_a;
      cs_n_nxt        = sram_cs_n;
      oe_n_nxt        = sram_oe_n;
      we_n_nxt        = sram_we_n;
      be_n_nxt        = sram_be_n;
      drive_nxt       = drive_q;
      case (state)
         S_IDLE: begin
            if (mem_waitrequest) begin
               // first cycle out of reset: open the port
               waitrequest_nxt = 1'b0;
            end else if (accept) begin
               waitrequest_nxt = 1'b1;
               sram_a_nxt      = word_addr;
               cs_n_nxt        = 1'b0;
               if (is_write) begin
                  we_n_nxt  = 1'b0;
                  oe_n_nxt  = 1'b1;
                  be_n_nxt  = ~mem_writedatamask;
                  drive_nxt = 1'b1;
               end else begin
                  oe_n_nxt  = 1'b0;
                  be_n_nxt  = 4'h0;
               end
            end
         end
         S_READ: begin
            if (wait_cnt == 3'd1) begin
               readdata_nxt    = sram_d;
               readdataid_nxt  = id_q;
               cs_n_nxt        = 1'b1;
               oe_n_nxt        = 1'b1;
               be_n_nxt        = 4'hF;
               waitrequest_nxt = 1'b0;
            end
         end
         S_WRITE: begin
            if (wait_cnt == 3'd1) begin
               we_n_nxt = 1'b1;
               cs_n_nxt = 1'b1;
               be_n_nxt = 4'hF;
            end
         end
         S_TURN: begin
            // data held through this cycle, released on the exit edge
            drive_nxt       = 1'b0;
            waitrequest_nxt = 1'b0;
         end
         default: begin
            drive_nxt = 1'b0;
         end
      endcase
   end

   // Output registers; reset forces strobes inactive and floats the bus at once
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_waitrequest <= 1'b1;
         mem_readdata    <= '0;
         mem_readdataid  <= '0;
         sram_a          <= '0;
         sram_cs_n       <= 1'b1;
         sram_oe_n       <= 1'b1;
         sram_we_n       <= 1'b1;
         sram_be_n       <= 4'hF;
         drive_q         <= 1'b0;
      end else begin
         mem_waitrequest <= waitrequest_nxt;
         mem_readdata    <= readdata_nxt;
         mem_readdataid  <= readdataid_nxt;
         sram_a          <= sram_a_nxt;
         sram_cs_n       <= cs_n_nxt;
         sram_oe_n       <= oe_n_nxt;
         sram_we_n       <= we_n_nxt;
         sram_be_n       <= be_n_nxt;
         drive_q         <= drive_nxt;
      end
   end

   // Capture requester tag and write data on accept
   always_ff @(posedge clock) begin
      if (accept) begin
         id_q <= mem_id;
         if (is_write) begin
            wdata_q <= mem_writedata;
         end
      end
   end

endmodule

// File: doc/sram_mem_port.md
# sram_mem_port

Bridges the CPU's tagged memory port (`mem_*`: waitrequest, 2-bit id, 30-bit word address, read/write, byte mask, tagged read return) to the board's asynchronous 32-bit SRAM on the shared Flash-SRAM-Ethernet bus. It is built from two 16-bit chips sharing address and control, with `fse_a[19:2]` as the word address. It sits directly downstream of the processor's memory port in the top level, and is the synthesis counterpart of the simulation block RAM. It owns the SRAM control strobes, the tri-state data bus and bus turnaround, and returns read data tagged with the requester's id.

## Interface
Parameters:
- `READ_WAIT`, 1: clock cycles SRAM is strobed (cs/oe low) before read data is sampled; legal 1..7.
- `WRITE_WAIT`, 1: clock cycles `sram_we_n` is held low per write; legal 1..7.
- `ADDR_BITS`, 18: word-address bits forwarded to SRAM; upper `mem_address` bits ignored (aliasing).

Ports:
- `clock` in 1: single clock, all state on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `mem_waitrequest` out 1: high = request not accepted this cycle.
- `mem_id` in 2: requester tag; 0 reserved (never issued).
- `mem_address` in 30: word address.
- `mem_read` in 1: read request.
- `mem_write` in 1: write request.
- `mem_writedata` in 32: write data.
- `mem_writedatamask` in 4: bit i=1 writes byte `[8i+7:8i]`.
- `mem_readdata` out 32: read data, valid when `mem_readdataid != 0`.
- `mem_readdataid` out 2: tag of returned data; 0 = no data this cycle.
- `sram_a` out 23: `{3'b0, addr[ADDR_BITS-1:0], 2'b00}`.
- `sram_d` inout 32: SRAM data bus.
- `sram_cs_n` out 1, `sram_oe_n` out 1, `sram_we_n` out 1: SRAM strobes, active-low.
- `sram_be_n` out 4: byte enables, active-low.

## Operation
- All outputs are registered. `sram_d` is driven from a registered output-enable and data register.
- FSM states: IDLE, READ, WRITE, TURN. A 3-bit wait counter is loaded on accept.
- Accept: in IDLE with `mem_waitrequest=0` and `mem_read|mem_write` high. At that edge, latch address and id. `mem_waitrequest` goes high at the same edge and stays high until the FSM re-enters IDLE.
- Simultaneous `mem_read` and `mem_write`: treated as a write. The read is dropped, not queued.
- READ:
  - On accept: `sram_cs_n=0`, `sram_oe_n=0`, `sram_be_n=4'h0`, counter=`READ_WAIT`.
  - Each edge in READ decrements the counter.
  - On the edge where the counter equals 1: sample `sram_d` into `mem_readdata`, set `mem_readdataid` to the latched id, raise `cs_n`/`oe_n`, go to IDLE.
- WRITE:
  - On accept: `sram_cs_n=0`, `sram_we_n=0`, `sram_oe_n=1`, `sram_be_n=~mask`, data driven, counter=`WRITE_WAIT`.
  - On the edge where the counter equals 1: `we_n=1`, `cs_n=1`, go to TURN.
- TURN: data is still driven for one cycle (hold), then tri-stated on the exit edge. Go to IDLE.
- Mask 4'b0000 on a write still runs the full cycle with `sram_be_n=4'hF`.
- `mem_readdataid` is nonzero for exactly one cycle per read. `mem_readdata` holds its last value otherwise.
- Invariant: `sram_oe_n=0` and the data-bus drive are never both active in the same cycle.

## Timing
- Reset values: `mem_waitrequest=1`, `mem_readdata=0`, `mem_readdataid=0`, `sram_a=0`, `sram_cs_n=1`, `sram_oe_n=1`, `sram_we_n=1`, `sram_be_n=4'hF`, `sram_d` high-Z, state IDLE.
- `mem_waitrequest` falls on the first rising edge after `reset_n` deasserts.
- Read latency: accept at edge E0 → `mem_readdataid` valid in the cycle after edge E0+`READ_WAIT`.
- Read occupancy is `READ_WAIT`+1 cycles per access. Default: a new request is accepted every 2 cycles.
- Write occupancy is `WRITE_WAIT`+2 cycles per access: WRITE_WAIT cycles of write pulse, 1 TURN, 1 IDLE accept.
- Address and `be_n` are stable for the whole cs-low window. Data is valid from the `we_n` fall to one cycle after the `we_n` rise.
- Reset mid-operation: all strobes go inactive and `sram_d` floats asynchronously. No read data is returned, and an in-flight write may be partial.
- Requests while `mem_waitrequest=1` are ignored. The master must hold them until accepted.

## Test plan
- Reset: hold `reset_n=0` 5 cycles → every output at its reset value, `sram_d` high-Z. Release → `mem_waitrequest=0` after 1 edge.
- Read, default params: SRAM model holds 0xDEADBEEF at word 0x123; read addr 0x123, id 2 → `sram_a=0x48C`, `oe_n` low 1 cycle, `mem_readdata=0xDEADBEEF`, `mem_readdataid=2` for exactly one cycle, 2 cycles after accept.
- Masked write then read: write 0xAABBCCDD mask 4'b0101 to a word holding 0x11223344 → `be_n=4'b1010`, `we_n` low 1 cycle. Readback returns 0x11BB33DD.
- Turnaround: write immediately followed by held read → `oe_n` low never overlaps data drive, the read is accepted 3 cycles after the write accept, and data is correct.
- Simultaneous `mem_read`+`mem_write` to addr 7 → only a write cycle occurs, no `mem_readdataid` pulse.
- Reset mid-op: assert `reset_n=0` in the WRITE state with `WRITE_WAIT=3` → `we_n`/`cs_n` high and bus floats without waiting for a clock edge. After release, the FSM is idle with no spurious readdataid.
